// File: rtl/acs_pmu_if.sv
// Symbol/decision bundle between the branch-metric front end,
// the ACS path-metric unit and the survivor traceback.
interface acs_pmu_if #(
  parameter int PM_W  = 6,
  parameter int CNT_W = 8
);
  logic             i_start;
  logic             i_valid;
  logic [1:0]       i_sym;
  logic             o_valid;
  logic [3:0]       o_dec;
  logic             o_comare_02;
  logic             o_comare_13;
  logic [PM_W-1:0]  o_pm0;
  logic [PM_W-1:0]  o_pm1;
  logic [PM_W-1:0]  o_pm2;
  logic [PM_W-1:0]  o_pm3;
  logic [1:0]       o_best_state;
  logic [CNT_W-1:0] o_sym_cnt;
  logic             o_frame_end;

  modport master (
    output i_start, i_valid, i_sym,
    input  o_valid, o_dec, o_comare_02, o_comare_13,
    input  o_pm0, o_pm1, o_pm2, o_pm3,
    input  o_best_state, o_sym_cnt, o_frame_end
  );

  modport slave (
    input  i_start, i_valid, i_sym,
    output o_valid, o_dec, o_comare_02, o_comare_13,
    output o_pm0, o_pm1, o_pm2, o_pm3,
    output o_best_state, o_sym_cnt, o_frame_end
  );
endinterface

// File: rtl/acs_pmu.sv
// Add-compare-select / path-metric unit for the 4-state K=3
// rate-1/2 (7,5) hard-decision Viterbi decoder.
module acs_pmu #(
  parameter int PM_W      = 6,
  parameter int INIT_PM   = 16,
  parameter int FRAME_LEN = 64,
  parameter int CNT_W     = 8
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  acs_pmu_if.slave  bus
);

  localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);
  localparam logic [PM_W:0]   MAX_V  = {1'b0, {PM_W{1'b1}}};
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [3:0][PM_W-1:0] INIT_VEC =
    {INIT_V, INIT_V, INIT_V, {PM_W{1'b0}}};

  logic [3:0][PM_W-1:0] pm_q, pm_d;
  logic [3:0]           dec_q, dec_d;
  logic                 valid_q, valid_d;
  logic                 fend_q, fend_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [3:0][PM_W-1:0] base;
  logic [3:0][PM_W:0]   cand_lo, cand_up, cand, diff;
  logic [3:0][PM_W-1:0] norm;
  logic [3:0]           dec_n;
  logic [PM_W:0]        mn01, mn23, mn;
  logic [CNT_W-1:0]     cnt_base;

  // Hamming distance to the pair emitted leaving state p on input u
  function automatic logic [1:0] bm_f(
    input logic [1:0] sym,
    input logic [1:0] p,
    input logic       u
  );
    logic c0, c1;
    c0 = u ^ p[1] ^ p[0];
    c1 = u ^ p[0];
    return {1'b0, sym[1] ^ c0} + {1'b0, sym[0] ^ c1};
  endfunction

  always_comb begin
    base     = bus.i_start ? INIT_VEC : pm_q;
    cnt_base = bus.i_start ? '0 : cnt_q;
    for (int n = 0; n < 4; n++) begin
      cand_lo[n] = {1'b0, base[{n[0], 1'b0}]}
        + {{(PM_W-1){1'b0}},
           bm_f(bus.i_sym, {n[0], 1'b0}, n[1])};
      cand_up[n] = {1'b0, base[{n[0], 1'b1}]}
        + {{(PM_W-1){1'b0}},
           bm_f(bus.i_sym, {n[0], 1'b1}, n[1])};
      dec_n[n] = cand_up[n] < cand_lo[n];
      cand[n]  = dec_n[n] ? cand_up[n] : cand_lo[n];
    end
    mn01 = (cand[1] < cand[0]) ? cand[1] : cand[0];
    mn23 = (cand[3] < cand[2]) ? cand[3] : cand[2];
    mn   = (mn23 < mn01) ? mn23 : mn01;
    for (int n = 0; n < 4; n++) begin
      diff[n] = cand[n] - mn;
      norm[n] = (diff[n] > MAX_V) ? MAX_V[PM_W-1:0]
                                  : diff[n][PM_W-1:0];
    end

    pm_d    = pm_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    fend_d  = 1'b0;
    if (bus.i_start) begin
      pm_d  = INIT_VEC;
      cnt_d = '0;
    end
    if (bus.i_valid) begin
      pm_d    = norm;
      dec_d   = dec_n;
      valid_d = 1'b1;
      if (cnt_base == LAST) begin
        cnt_d  = '0;
        fend_d = 1'b1;
      end else begin
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pm_q    <= INIT_VEC;
      dec_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      fend_q  <= 1'b0;
    end else begin
      pm_q    <= pm_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      fend_q  <= fend_d;
    end
  end

  logic [1:0] b01, b23;

  // Ties resolve toward the lower state index
  always_comb begin
    b01 = (pm_q[1] < pm_q[0]) ? 2'd1 : 2'd0;
    b23 = (pm_q[3] < pm_q[2]) ? 2'd3 : 2'd2;
    bus.o_best_state = (pm_q[b23] < pm_q[b01]) ? b23 : b01;
  end

  assign bus.o_valid     = valid_q;
  assign bus.o_dec       = dec_q;
  assign bus.o_pm0       = pm_q[0];
  assign bus.o_pm1       = pm_q[1];
  assign bus.o_pm2       = pm_q[2];
  assign bus.o_pm3       = pm_q[3];
  assign bus.o_comare_02 = pm_q[0] <= pm_q[2];
  assign bus.o_comare_13 = pm_q[1] <= pm_q[3];
  assign bus.o_sym_cnt   = cnt_q;
  assign bus.o_frame_end = fend_q;

endmodule
